c5_niosii_spi_slvsec_pll_rst_seq: RTL and testbench

//  Reset sequencer directly downstream of the system PLL. Runs on the free-running 50 MHz board clock.

---
 rtl/c5_niosii_spi_slvsec_pll_rst_seq_pkg.sv | 47 ++++
 rtl/c5_niosii_spi_slvsec_pll_rst_seq_if.sv | 25 ++
 rtl/c5_niosii_spi_slvsec_pll_rst_seq_sync.sv | 18 +
 rtl/c5_niosii_spi_slvsec_pll_rst_seq.sv | 118 +++++++++++
 tb/tb_c5_niosii_spi_slvsec_pll_rst_seq.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/c5_niosii_spi_slvsec_pll_rst_seq_pkg.sv
// Shared types for the PLL reset sequencer: state encoding, registered output bundle
// and the helper that derives the output levels for each state.
package c5_pll_rst_seq_pkg;

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    localparam int SYNC_STAGES = 2;

    typedef struct packed {
        logic pll_rst;
        logic reset_out;
        logic ready;
        logic fault;
    } outs_t;

    // Output levels that hold for the whole time the FSM sits in state s.
    function automatic outs_t outs_of(state_t s);
        outs_t o;
        o = '{pll_rst: 1'b0, reset_out: 1'b1, ready: 1'b0, fault: 1'b0};
        case (s)
            S_PLL_RST: o.pll_rst = 1'b1;
            S_RUN: begin
                o.reset_out = 1'b0;
                o.ready     = 1'b1;
            end
            S_FAULT: begin
                o.pll_rst = 1'b1;
                o.fault   = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

    function automatic int max3(int a, int b, int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/c5_niosii_spi_slvsec_pll_rst_seq_if.sv
// PLL-side / system-side signal bundle of the reset sequencer.
// master = the sequencer, slave = the PLL plus reset consumers.
interface c5_niosii_spi_slvsec_pll_rst_seq_if #(
    parameter int MAX_RETRIES = 3
);
    localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

    logic          pll_locked;
    logic          pll_rst;
    logic          reset_out;
    logic          ready;
    logic          fault;
    logic [RW-1:0] retry_cnt;
    logic [2:0]    state_dbg;

    modport master (
        input  pll_locked,
        output pll_rst, reset_out, ready, fault, retry_cnt, state_dbg
    );

    modport slave (
        output pll_locked,
        input  pll_rst, reset_out, ready, fault, retry_cnt, state_dbg
    );
endinterface

// File: rtl/c5_niosii_spi_slvsec_pll_rst_seq_sync.sv
// Generic multi-flop level synchronizer with asynchronous clear to 0.
module c5_bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) ff <= '0;
        else     ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];
endmodule

// File: rtl/c5_niosii_spi_slvsec_pll_rst_seq.sv
// PLL reset sequencer: pulses pll_rst, waits for a stable lock, releases reset_out.
// Define C5_PLL_RELOCK_EN to re-pulse the PLL on lock loss in RUN instead of waiting for self-relock.
module c5_niosii_spi_slvsec_pll_rst_seq
    import c5_pll_rst_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES    = 3
) (
    input  logic refclk,
    input  logic rst,
    c5_niosii_spi_slvsec_pll_rst_seq_if.master pll_if
);
    localparam int CNT_MAX = max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int RW      = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

    localparam logic [CW-1:0] PLL_LAST    = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [RW-1:0] retry;
    outs_t         o_q;
    logic          locked_s;

    c5_bit_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk (refclk),
        .clr (rst),
        .d   (pll_if.pll_locked),
        .q   (locked_s)
    );

    // Every transition loads the new state's output levels, so outputs stay registered
    // and change on the same edge as the state.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state <= S_PLL_RST;
            cnt   <= '0;
            retry <= '0;
            o_q   <= outs_of(S_PLL_RST);
        end else begin
            case (state)
                S_PLL_RST: begin
                    if (cnt == PLL_LAST) begin
                        state <= S_WAIT_LOCK;
                        cnt   <= '0;
                        o_q   <= outs_of(S_WAIT_LOCK);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (locked_s) begin
                        state <= S_STABLE;
                        cnt   <= '0;
                        o_q   <= outs_of(S_STABLE);
                    end else if (cnt == TIMEOUT_LAST) begin
                        cnt <= '0;
                        if (retry == RETRY_MAX) begin
                            state <= S_FAULT;
                            o_q   <= outs_of(S_FAULT);
                        end else begin
                            retry <= retry + 1'b1;
                            state <= S_PLL_RST;
                            o_q   <= outs_of(S_PLL_RST);
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!locked_s) begin
                        // Lock dropped before it proved stable: new timeout window, not a retry.
                        state <= S_WAIT_LOCK;
                        cnt   <= '0;
                        o_q   <= outs_of(S_WAIT_LOCK);
                    end else if (cnt == STABLE_LAST) begin
                        state <= S_RUN;
                        cnt   <= '0;
                        retry <= '0;
                        o_q   <= outs_of(S_RUN);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!locked_s) begin
                        cnt <= '0;
`ifdef C5_PLL_RELOCK_EN
                        state <= S_PLL_RST;
                        o_q   <= outs_of(S_PLL_RST);
`else
                        state <= S_WAIT_LOCK;
                        o_q   <= outs_of(S_WAIT_LOCK);
`endif
                    end
                end
                S_FAULT: ;
                default: begin
                    state <= S_PLL_RST;
                    cnt   <= '0;
                    o_q   <= outs_of(S_PLL_RST);
                end
            endcase
        end
    end

    assign pll_if.pll_rst   = o_q.pll_rst;
    assign pll_if.reset_out = o_q.reset_out;
    assign pll_if.ready     = o_q.ready;
    assign pll_if.fault     = o_q.fault;
    assign pll_if.retry_cnt = retry;
    assign pll_if.state_dbg = state;
endmodule

// File: tb/tb_c5_niosii_spi_slvsec_pll_rst_seq.sv
// Directed + randomized-timing bench for the PLL reset sequencer; expectations come from
// latency arithmetic (sync depth, pulse length, timeout and stability windows).
module tb_c5_niosii_spi_slvsec_pll_rst_seq;
    localparam int PRC  = 4;
    localparam int LT   = 20;
    localparam int SC   = 8;
    localparam int MR   = 2;
    localparam int SYNC = 2;
    // Samples from pll_locked rising (set just before an edge) to the first sample with reset_out low.
    localparam int REL = SYNC + SC + 1;
    // Edge on which the first WAIT_LOCK window times out.
    localparam int TO_EDGE = PRC + LT - 1;
    localparam int PERIOD  = PRC + LT;
    localparam int FAULT_AT = (MR + 1) * PERIOD;
`ifdef C5_PLL_RELOCK_EN
    localparam int LOSS_ST = 0;
`else
    localparam int LOSS_ST = 1;
`endif

    logic refclk = 1'b0;
    logic rst    = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   e      = 0;

    c5_niosii_spi_slvsec_pll_rst_seq_if #(.MAX_RETRIES(MR)) bus ();

    c5_niosii_spi_slvsec_pll_rst_seq #(
        .PLL_RST_CYCLES (PRC),
        .LOCK_TIMEOUT   (LT),
        .STABLE_CYCLES  (SC),
        .MAX_RETRIES    (MR)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .pll_if (bus)
    );

    always #5 refclk = ~refclk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Sampling and driving both happen on the falling edge; e indexes the next rising edge from t0.
    task automatic cyc();
        @(negedge refclk);
        e++;
    endtask

    task automatic do_reset();
        @(negedge refclk);
        rst = 1'b1;
        bus.pll_locked = 1'b0;
        @(negedge refclk);
        @(negedge refclk);
        rst = 1'b0;
        e = 0;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_pll_rst"},   bus.pll_rst,   1);
        chk({pfx, "_reset_out"}, bus.reset_out, 1);
        chk({pfx, "_ready"},     bus.ready,     0);
        chk({pfx, "_fault"},     bus.fault,     0);
        chk({pfx, "_retry_cnt"}, bus.retry_cnt, 0);
        chk({pfx, "_state"},     bus.state_dbg, 0);
    endtask

    initial begin
        int L, D, R, bad, rel;
        bus.pll_locked = 1'b0;
        rst = 1'b1;
        @(negedge refclk);
        chk_reset_vals("reset");

        // Nominal bring-up: lock at t0+10, then a random lock time inside the first window.
        for (int it = 0; it < 2; it++) begin
            do_reset();
            L = (it == 0) ? 10 : $urandom_range(2, TO_EDGE - SYNC - 3);
            bad = 0;
            while (e < L + REL + 4) begin
                if (e == L) bus.pll_locked = 1'b1;
                if (bus.pll_rst !== (e < PRC)) bad++;
                if (bus.reset_out !== (e < L + REL)) bad++;
                if (bus.ready !== (e >= L + REL)) bad++;
                if (bus.retry_cnt !== '0) bad++;
                cyc();
            end
            chk("s1_nominal_trace", bad, 0);
            chk("s1_state_run", bus.state_dbg, 3);
            chk("s1_fault", bus.fault, 0);
        end

        // Glitch during STABLE: three low cycles send it back to WAIT_LOCK.
        do_reset();
        L = $urandom_range(2, 10);
        rel = L + 8 + REL;
        bad = 0;
        while (e < rel + 3) begin
            if (e == L || e == L + 8) bus.pll_locked = 1'b1;
            if (e == L + 5) bus.pll_locked = 1'b0;
            if (e == L + 8) chk("s2_back_to_wait", bus.state_dbg, 1);
            if (bus.reset_out !== (e < rel)) bad++;
            if (bus.pll_rst !== (e < PRC)) bad++;
            cyc();
        end
        chk("s2_glitch_trace", bad, 0);
        chk("s2_ready", bus.ready, 1);

        // Lock never comes: MR+1 pulses, one per window, then sticky FAULT.
        do_reset();
        bad = 0;
        while (e < FAULT_AT + 120) begin
            if (e < FAULT_AT) begin
                if (bus.pll_rst !== ((e % PERIOD) < PRC)) bad++;
                if (bus.retry_cnt !== (e / PERIOD)) bad++;
                if (bus.fault !== 1'b0) bad++;
            end else begin
                if (bus.pll_rst !== 1'b1) bad++;
                if (bus.retry_cnt !== MR) bad++;
                if (bus.fault !== 1'b1) bad++;
            end
            if (bus.reset_out !== 1'b1 || bus.ready !== 1'b0) bad++;
            cyc();
        end
        chk("s3_timeout_trace", bad, 0);
        chk("s3_fault", bus.fault, 1);
        chk("s3_retry_cnt", bus.retry_cnt, MR);
        chk("s3_state_fault", bus.state_dbg, 4);

        // Lock lost in RUN, then regained.
        do_reset();
        L = $urandom_range(2, 8);
        while (e < L + REL) begin
            if (e == L) bus.pll_locked = 1'b1;
            cyc();
        end
        chk("s4_run_ready", bus.ready, 1);
        D = e + $urandom_range(1, 5);
        R = D + 5 + $urandom_range(0, 5);
        bad = 0;
        while (e < R + REL + 3) begin
            if (e == D) bus.pll_locked = 1'b0;
            if (e == R) bus.pll_locked = 1'b1;
            if (bus.reset_out !== (e >= D + 3 && e < R + REL)) bad++;
            if (bus.ready !== !(e >= D + 3 && e < R + REL)) bad++;
`ifdef C5_PLL_RELOCK_EN
            if (bus.pll_rst !== (e >= D + 3 && e < D + 3 + PRC)) bad++;
`else
            if (bus.pll_rst !== 1'b0) bad++;
`endif
            if (e == D + 3) begin
                chk("s4_loss_state", bus.state_dbg, LOSS_ST);
                chk("s4_loss_reset_out", bus.reset_out, 1);
            end
            cyc();
        end
        chk("s4_loss_trace", bad, 0);
        chk("s4_retry_cnt", bus.retry_cnt, 0);

        // Asynchronous reset in the middle of STABLE, then a full re-run.
        do_reset();
        L = $urandom_range(2, 6);
        while (e < L + 6) begin
            if (e == L) bus.pll_locked = 1'b1;
            cyc();
        end
        chk("s5_in_stable", bus.state_dbg, 2);
        #1 rst = 1'b1;
        #1;
        chk_reset_vals("s5_async");
        #1 rst = 1'b0;
        e = 0;
        bad = 0;
        while (e < PRC + SC + 4) begin
            cyc();
            if (bus.pll_rst !== (e < PRC)) bad++;
            if (bus.reset_out !== (e < PRC + SC + 1)) bad++;
        end
        chk("s5_rerun_trace", bad, 0);

        // Lock seen exactly on the timeout edge wins.
        do_reset();
        L = TO_EDGE - SYNC;
        while (e < TO_EDGE + 1) begin
            if (e == L) bus.pll_locked = 1'b1;
            cyc();
        end
        chk("s6_lock_wins_state", bus.state_dbg, 2);
        chk("s6_lock_wins_retry", bus.retry_cnt, 0);
        chk("s6_lock_wins_pll_rst", bus.pll_rst, 0);
        while (bus.reset_out !== 1'b0 && e < 80) cyc();
        chk("s6_lock_wins_release", e, L + REL);

        // One edge too late: the timeout retry happens first.
        do_reset();
        L = TO_EDGE - SYNC + 1;
        while (e < TO_EDGE + 1) begin
            if (e == L) bus.pll_locked = 1'b1;
            cyc();
        end
        chk("s6_late_state", bus.state_dbg, 0);
        chk("s6_late_retry", bus.retry_cnt, 1);
        chk("s6_late_pll_rst", bus.pll_rst, 1);
        while (bus.reset_out !== 1'b0 && e < 80) cyc();
        chk("s6_late_release", e, TO_EDGE + PRC + 1 + SC + 1);
        chk("s6_late_retry_cleared", bus.retry_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
